// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared image constants and window generator state type
//
// Purpose: image geometry shared by cnn_win_gen and cnn_core, plus the window
// generator FSM state encoding.
package cnn_pkg;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        DONE
    } win_state_t;

endpackage

// File: rtl/cnn_line_buf.sv
// rtl/cnn_line_buf.sv - K-row streaming line buffer with KxK window taps
//
// Purpose: K*IMG_W-bit shift register holding the most recent K image rows.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   shift     - shift din into sr[0] this cycle
//   din       - incoming pixel
//   clr       - clear the whole register (wins over shift)
//   taps      - KxK window, taps[K*i+j] = pixel(top+i, left+j)
module cnn_line_buf #(
    parameter int IMG_W = 28,
    parameter int K     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             din,
    input  logic             clr,
    output logic [K*K-1:0]   taps
);

    logic [K*IMG_W-1:0] sr_q;
    logic [K*IMG_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (shift) begin
            sr_d = {sr_q[K*IMG_W-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // The newest pixel sits at sr[0] and is the bottom-right of the window;
    // each row up is IMG_W positions older, each column left is one older.
    always_comb begin
        taps = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                taps[K*i+j] = sr_q[(K-1-i)*IMG_W + (K-1-j)];
            end
        end
    end

endmodule

// File: rtl/cnn_win_gen.sv
// rtl/cnn_win_gen.sv - unpacks UART image bytes and emits every 3x3 window
//
// Purpose: bytes arrive LSB-first as raster-order binary pixels; each pixel is
// shifted into the line buffer and every complete window is held on win until
// the core accepts it.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   rx_rdy, rx_data    - one-cycle byte strobe and image byte
//   frm_clr            - synchronous frame abort, same effect as rst
//   win_rdy            - core accepts the presented window
//   win_vld, win       - window valid (held until accepted) and pixels
//   win_row, win_col   - top-left coordinate of the presented window
//   frm_done           - one-cycle pulse after the last window is accepted
//   ovf                - sticky: a byte arrived while not in IDLE
module cnn_win_gen #(
    parameter int IMG_W = cnn_pkg::IMG_W,
    parameter int IMG_H = cnn_pkg::IMG_H,
    parameter int K     = cnn_pkg::K
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_rdy,
    input  logic [7:0]       rx_data,
    input  logic             frm_clr,
    input  logic             win_rdy,
    output logic             win_vld,
    output logic [K*K-1:0]   win,
    output logic [4:0]       win_row,
    output logic [4:0]       win_col,
    output logic             frm_done,
    output logic             ovf
);

    import cnn_pkg::*;

    localparam logic [4:0] LAST_ROW = 5'(IMG_H - 1);
    localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
    localparam logic [4:0] END_ROW  = 5'(IMG_H);
    localparam logic [4:0] EDGE     = 5'(K - 1);

    win_state_t  state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        win_vld_q, win_vld_d;
    logic [4:0]  win_row_q, win_row_d;
    logic [4:0]  win_col_q, win_col_d;
    logic        frm_done_q, frm_done_d;
    logic        ovf_q, ovf_d;

    logic        buf_shift;
    logic        buf_din;
    logic        buf_clr;
    logic [K*K-1:0] buf_taps;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        win_vld_d  = win_vld_q;
        win_row_d  = win_row_q;
        win_col_d  = win_col_q;
        frm_done_d = 1'b0;
        ovf_d      = ovf_q;
        buf_shift  = 1'b0;
        buf_clr    = 1'b0;
        buf_din    = byte_q[bit_cnt_q];

        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    byte_d    = rx_data;
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // row_q/col_q name the pixel leaving the byte this cycle.
                buf_shift = 1'b1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (col_q == LAST_COL) begin
                    col_d = 5'd0;
                    row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 5'd1;
                end
                if (row_q >= EDGE && col_q >= EDGE) begin
                    state_d   = HOLD;
                    win_vld_d = 1'b1;
                    win_row_d = row_q - EDGE;
                    win_col_d = col_q - EDGE;
                end else if (row_q == LAST_ROW && col_q == LAST_COL) begin
                    state_d    = DONE;
                    frm_done_d = 1'b1;
                end else if (bit_cnt_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (win_rdy) begin
                    win_vld_d = 1'b0;
                    // Row counter has already stepped past the last row once
                    // the final pixel is in; bit_cnt wraps to 0 after bit 7.
                    if (row_q == END_ROW) begin
                        state_d    = DONE;
                        frm_done_d = 1'b1;
                    end else if (bit_cnt_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            DONE: begin
                row_d   = 5'd0;
                col_d   = 5'd0;
                buf_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_rdy && state_q != IDLE) begin
            ovf_d = 1'b1;
        end

        // Abort overrides everything, including a byte or acceptance this cycle.
        if (frm_clr) begin
            state_d    = IDLE;
            row_d      = 5'd0;
            col_d      = 5'd0;
            bit_cnt_d  = 3'd0;
            byte_d     = 8'd0;
            win_vld_d  = 1'b0;
            win_row_d  = 5'd0;
            win_col_d  = 5'd0;
            frm_done_d = 1'b0;
            ovf_d      = 1'b0;
            buf_shift  = 1'b0;
            buf_clr    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            bit_cnt_q  <= 3'd0;
            byte_q     <= 8'd0;
            win_vld_q  <= 1'b0;
            win_row_q  <= 5'd0;
            win_col_q  <= 5'd0;
            frm_done_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            win_vld_q  <= win_vld_d;
            win_row_q  <= win_row_d;
            win_col_q  <= win_col_d;
            frm_done_q <= frm_done_d;
            ovf_q      <= ovf_d;
        end
    end

    cnn_line_buf #(
        .IMG_W (IMG_W),
        .K     (K)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .shift (buf_shift),
        .din   (buf_din),
        .clr   (buf_clr),
        .taps  (buf_taps)
    );

    // Taps come straight from buffer flops, which do not move while held.
    assign win      = buf_taps;
    assign win_vld  = win_vld_q;
    assign win_row  = win_row_q;
    assign win_col  = win_col_q;
    assign frm_done = frm_done_q;
    assign ovf      = ovf_q;

endmodule
